x_top_mem_resp: RTL and testbench
=================================

X_TOP_MEM_RESP -- requirements
Module: x_top_mem_resp

Interface
REQ-001 The block SHALL have parameters p_clk_hz (default 1000000, system clock in Hz), p_baud (default 9600, UART bit rate) and p_timeout (default 100000, inter-byte timeout in cycles).
REQ-002 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 i_nrst  in  1  reset, asynchronous and active-low.
REQ-004 i_rx  in  1  UART receive line from the initiator.
REQ-005 o_tx  out  1  UART transmit line to the initiator.
REQ-006 o_valid  out  1  memory request valid.
REQ-007 o_rnw  out  1  memory request type: 1 read, 0 write.
REQ-008 i_accept  in  1  memory completion; the request is done in any cycle where o_valid and i_accept are both 1.
REQ-009 o_addr  out  32  memory address.
REQ-010 o_data  out  32  memory write data.
REQ-011 i_data  in  32  memory read data, sampled in the accept cycle of a read.

Function
REQ-012 UART framing SHALL use x_top_uart_rx and x_top_uart_tx, instantiated with p_clk_hz and p_baud.
REQ-013 Frame protocol: command byte 0x00 is a write and 0x01 is a read, followed by 4 address bytes LSB first.
- A write then carries 4 data bytes, LSB first.
- All multi-byte fields are little-endian.
REQ-014 Each accepted command, address or write-data byte SHALL be acknowledged by transmitting the same byte value back (echo).
REQ-015 Any other command byte received in IDLE SHALL be discarded: no echo, state stays IDLE.
REQ-016 FSM states: IDLE, A0-A3, D0-D3, MEM, RSP0-RSP3, DONE.
- IDLE -> A0 on a valid command; o_rnw is latched from the command.
- A0-A3: each received byte is stored into o_addr[8k+7:8k] and the FSM advances.
- After A3: a write -> D0; a read -> MEM.
- D0-D3: each received byte is stored into o_data[8k+7:8k]; D3 -> MEM.
REQ-017 MEM: o_valid SHALL be 1 from the first cycle after the last address/data byte's echo is accepted by the UART transmitter until the i_accept cycle inclusive.
- o_valid drops the cycle after accept.
- Write: MEM -> DONE.
- Read: i_data is captured into a 32-bit register; MEM -> RSP0.
REQ-018 DONE (write only): transmit completion byte 0x00, then -> IDLE once the UART transmitter accepts it.
REQ-019 RSP0-RSP3 (read only): transmit read byte k (LSB first), then wait for any received byte as the initiator's ack.
- On that ack, advance to the next RSP state.
- RSP3 ack -> IDLE.
- Ack bytes are not echoed.
REQ-020 Transmit handshake: the byte and its valid are registered and held stable until the transmitter accepts them.
- Only one transmit byte is outstanding at a time.
REQ-021 A byte received while an echo is still outstanding SHALL be discarded with no state change.
REQ-022 Timeout counter behaviour:
- Counts cycles while the state is not IDLE, MEM or DONE.
- Clears on every received byte and on every state change.
- On reaching p_timeout, the FSM returns to IDLE and the partial frame is dropped; o_addr/o_data keep their values.
REQ-023 MEM SHALL never time out: a started bus request always completes.
REQ-024 o_addr, o_data and o_rnw SHALL be stable while o_valid is 1.

Reset
REQ-025 While i_nrst is low, the block SHALL hold the following values:
- FSM at IDLE; o_valid 0; o_rnw 0; o_addr 0; o_data 0.
- Timeout counter 0; no transmit pending; o_tx 1 (line idle).
REQ-026 Reset asserted mid-frame or mid-MEM SHALL abort immediately; no echo or completion byte is sent after release.

Verification
REQ-027 Write: rx 00,10,00,00,80,EF,BE,AD,DE -> 9 echoed bytes; o_valid=1, o_rnw=0, o_addr=0x80000010, o_data=0xDEADBEEF; i_accept after 3 cycles -> tx 0x00, return to IDLE.
REQ-028 Read: rx 01,04,00,00,00 -> 5 echoes; o_valid=1, o_rnw=1, o_addr=0x00000004; i_data=0x12345678 on accept -> tx 78, then 56, 34 and 12, each sent only after one rx ack byte.
REQ-029 Bad command: rx 0x5A in IDLE -> no tx activity, o_valid stays 0; a following valid write frame completes normally.
REQ-030 Timeout: rx 00,10 then silence for p_timeout cycles -> IDLE, no o_valid; a new frame is accepted. With p_timeout=1000, hold i_accept=0 in MEM for 5000 cycles -> o_valid stays 1.
REQ-031 Reset mid-read in RSP1 -> o_tx=1, o_valid=0, o_addr=0 at release; the next frame works.

Source files
------------

// File: rtl/x_top_mem_resp.sv
// UART-driven memory request bridge: decodes read/write frames from a serial
// initiator, issues one bus request per frame and returns echo/response bytes.

module x_top_uart_rx #(
    parameter int p_clk_hz = 1000000,
    parameter int p_baud   = 9600
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data
);
    localparam int         CPB     = p_clk_hz / p_baud;
    localparam logic [15:0] BIT_M1  = 16'(CPB - 1);
    localparam logic [15:0] HALF_M1 = 16'(CPB / 2 - 1);
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]  sync_r;
    logic [1:0]  state_r;
    logic [15:0] cnt_r;
    logic [2:0]  bit_r;
    logic [7:0]  shift_r;
    logic        valid_r;

    // Synchronise the line, then sample each bit at its midpoint.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sync_r  <= 2'b11;
            state_r <= RX_IDLE;
            cnt_r   <= 16'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            valid_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], i_rx};
            valid_r <= 1'b0;
            case (state_r)
                RX_IDLE: begin
                    cnt_r <= 16'd0;
                    if (!sync_r[1]) state_r <= RX_START;
                end
                RX_START: begin
                    if (cnt_r == HALF_M1) begin
                        cnt_r   <= 16'd0;
                        bit_r   <= 3'd0;
                        state_r <= sync_r[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == BIT_M1) begin
                        cnt_r   <= 16'd0;
                        shift_r <= {sync_r[1], shift_r[7:1]};
                        bit_r   <= bit_r + 3'd1;
                        if (bit_r == 3'd7) state_r <= RX_STOP;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == BIT_M1) begin
                        cnt_r   <= 16'd0;
                        valid_r <= sync_r[1];
                        state_r <= RX_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: state_r <= RX_IDLE;
            endcase
        end
    end

    assign o_valid = valid_r;
    assign o_data  = shift_r;
endmodule

module x_top_uart_tx #(
    parameter int p_clk_hz = 1000000,
    parameter int p_baud   = 9600
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);
    localparam int          CPB    = p_clk_hz / p_baud;
    localparam logic [15:0] BIT_M1 = 16'(CPB - 1);

    logic        busy_r;
    logic [8:0]  sh_r;
    logic [15:0] cnt_r;
    logic [3:0]  nbit_r;
    logic        tx_r;

    // Start bit, eight data bits LSB first, one full stop bit before ready again.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            busy_r <= 1'b0;
            sh_r   <= 9'h1FF;
            cnt_r  <= 16'd0;
            nbit_r <= 4'd0;
            tx_r   <= 1'b1;
        end else if (!busy_r) begin
            if (i_valid) begin
                busy_r <= 1'b1;
                sh_r   <= {1'b1, i_data};
                tx_r   <= 1'b0;
                cnt_r  <= 16'd0;
                nbit_r <= 4'd0;
            end
        end else if (cnt_r == BIT_M1) begin
            cnt_r <= 16'd0;
            if (nbit_r == 4'd9) begin
                busy_r <= 1'b0;
            end else begin
                tx_r   <= sh_r[0];
                sh_r   <= {1'b1, sh_r[8:1]};
                nbit_r <= nbit_r + 4'd1;
            end
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign o_ready = !busy_r;
    assign o_tx    = tx_r;
endmodule

module x_top_mem_resp #(
    parameter int p_clk_hz  = 1000000,
    parameter int p_baud    = 9600,
    parameter int p_timeout = 100000
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_rx,
    output logic        o_tx,
    output logic        o_valid,
    output logic        o_rnw,
    input  logic        i_accept,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    input  logic [31:0] i_data
);
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_A0   = 4'd1;
    localparam logic [3:0] ST_A1   = 4'd2;
    localparam logic [3:0] ST_A2   = 4'd3;
    localparam logic [3:0] ST_A3   = 4'd4;
    localparam logic [3:0] ST_D0   = 4'd5;
    localparam logic [3:0] ST_D1   = 4'd6;
    localparam logic [3:0] ST_D2   = 4'd7;
    localparam logic [3:0] ST_D3   = 4'd8;
    localparam logic [3:0] ST_MEM  = 4'd9;
    localparam logic [3:0] ST_RSP0 = 4'd10;
    localparam logic [3:0] ST_RSP1 = 4'd11;
    localparam logic [3:0] ST_RSP2 = 4'd12;
    localparam logic [3:0] ST_RSP3 = 4'd13;
    localparam logic [3:0] ST_DONE = 4'd14;
    localparam logic [31:0] TMO_M1 = 32'(p_timeout - 1);

    logic        rx_valid_s;
    logic [7:0]  rx_byte_s;
    logic        tx_ready_s;
    logic [3:0]  state_r;
    logic [3:0]  state_nxt_s;
    logic [31:0] tmo_cnt_r;
    logic        tx_valid_r;
    logic [7:0]  tx_byte_r;
    logic        valid_r;
    logic        rnw_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic [23:0] rdata_hi_r;
    logic        rx_take_s;
    logic        tx_accept_s;
    logic        mem_fire_s;
    logic        counting_s;
    logic        timeout_s;
    logic        load_s;
    logic [7:0]  load_byte_s;

    x_top_uart_rx #(.p_clk_hz(p_clk_hz), .p_baud(p_baud)) u_rx (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_rx   (i_rx),
        .o_valid(rx_valid_s),
        .o_data (rx_byte_s)
    );

    x_top_uart_tx #(.p_clk_hz(p_clk_hz), .p_baud(p_baud)) u_tx (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_valid(tx_valid_r),
        .i_data (tx_byte_r),
        .o_ready(tx_ready_s),
        .o_tx   (o_tx)
    );

    // Frame sequencing; a byte is only taken when no transmit byte is outstanding.
    always_comb begin
        rx_take_s   = rx_valid_s && !tx_valid_r;
        tx_accept_s = tx_valid_r && tx_ready_s;
        mem_fire_s  = valid_r && i_accept;
        counting_s  = (state_r != ST_IDLE) && (state_r != ST_MEM) && (state_r != ST_DONE);
        timeout_s   = counting_s && (tmo_cnt_r >= TMO_M1) && !rx_valid_s;
        state_nxt_s = state_r;
        load_s      = 1'b0;
        load_byte_s = rx_byte_s;
        if (timeout_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_take_s && (rx_byte_s == 8'h00 || rx_byte_s == 8'h01)) begin
                        state_nxt_s = ST_A0;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_A0, ST_A1, ST_A2, ST_D0, ST_D1, ST_D2: begin
                    if (rx_take_s) begin
                        state_nxt_s = state_r + 4'd1;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_A3, ST_D3: begin
                    if (rx_take_s) begin
                        state_nxt_s = (state_r == ST_A3 && !rnw_r) ? ST_D0 : ST_MEM;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_MEM: begin
                    if (mem_fire_s) begin
                        state_nxt_s = rnw_r ? ST_RSP0 : ST_DONE;
                        load_s      = 1'b1;
                        load_byte_s = rnw_r ? i_data[7:0] : 8'h00;
                    end else begin
                        state_nxt_s = ST_MEM;
                    end
                end
                ST_DONE: begin
                    if (tx_accept_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                ST_RSP0, ST_RSP1, ST_RSP2: begin
                    if (rx_take_s) begin
                        state_nxt_s = state_r + 4'd1;
                        load_s      = 1'b1;
                        case (state_r)
                            ST_RSP0: load_byte_s = rdata_hi_r[7:0];
                            ST_RSP1: load_byte_s = rdata_hi_r[15:8];
                            default: load_byte_s = rdata_hi_r[23:16];
                        endcase
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_RSP3: begin
                    if (rx_take_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RSP3;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register and inter-byte timeout counter.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (!counting_s || rx_valid_s || (state_nxt_s != state_r)) begin
                tmo_cnt_r <= 32'd0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + 32'd1;
            end
        end
    end

    // Transmit slot, bus request and captured fields.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            tx_valid_r <= 1'b0;
            tx_byte_r  <= 8'h00;
            valid_r    <= 1'b0;
            rnw_r      <= 1'b0;
            addr_r     <= 32'd0;
            data_r     <= 32'd0;
            rdata_hi_r <= 24'd0;
        end else begin
            if (load_s) begin
                tx_valid_r <= 1'b1;
                tx_byte_r  <= load_byte_s;
            end else if (tx_accept_s) begin
                tx_valid_r <= 1'b0;
            end
            // Request goes out only once the final echo has been handed to the transmitter.
            if (mem_fire_s) begin
                valid_r <= 1'b0;
            end else if (state_r == ST_MEM && (!tx_valid_r || tx_accept_s)) begin
                valid_r <= 1'b1;
            end
            if (mem_fire_s && rnw_r) rdata_hi_r <= i_data[31:8];
            if (state_r == ST_IDLE && state_nxt_s == ST_A0) rnw_r <= rx_byte_s[0];
            if (rx_take_s) begin
                case (state_r)
                    ST_A0:   addr_r[7:0]   <= rx_byte_s;
                    ST_A1:   addr_r[15:8]  <= rx_byte_s;
                    ST_A2:   addr_r[23:16] <= rx_byte_s;
                    ST_A3:   addr_r[31:24] <= rx_byte_s;
                    ST_D0:   data_r[7:0]   <= rx_byte_s;
                    ST_D1:   data_r[15:8]  <= rx_byte_s;
                    ST_D2:   data_r[23:16] <= rx_byte_s;
                    ST_D3:   data_r[31:24] <= rx_byte_s;
                    default: addr_r        <= addr_r;
                endcase
            end
        end
    end

    assign o_valid = valid_r;
    assign o_rnw   = rnw_r;
    assign o_addr  = addr_r;
    assign o_data  = data_r;
endmodule

// File: tb/tb_x_top_mem_resp.sv
// Bench for x_top_mem_resp: serial initiator + bus responder, checked against a
// frame-level model of the expected byte stream and bus request.

module tb_x_top_mem_resp;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int TMO    = 1000;
    localparam int CPB    = CLK_HZ / BAUD;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic        is_read;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        int          exp_len;
    } vec_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        rx;
    logic        tx;
    logic        valid;
    logic        rnw;
    logic        accept;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata_in;
    logic [7:0]  rxq[$];
    logic [31:0] last_wdata;
    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        tbl[5];

    always #5 clk = ~clk;

    x_top_mem_resp #(.p_clk_hz(CLK_HZ), .p_baud(BAUD), .p_timeout(TMO)) dut (
        .i_clk   (clk),
        .i_nrst  (nrst),
        .i_rx    (rx),
        .o_tx    (tx),
        .o_valid (valid),
        .o_rnw   (rnw),
        .i_accept(accept),
        .o_addr  (addr),
        .o_data  (data),
        .i_data  (rdata_in)
    );

    // Serial monitor on the DUT transmit line.
    initial begin
        logic [7:0] mb;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mb[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                rxq.push_back(mb);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input string name);
        int t = 0;
        while (rxq.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, {31'd0, rxq.size() >= n}, 32'd1);
    endtask

    task automatic wait_valid(output logic ok);
        int t = 0;
        while (valid !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        ok = (valid === 1'b1);
    endtask

    // Expected serial stream for one complete frame.
    function automatic bq_t model(input logic is_read, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd);
        bq_t q;
        q.push_back(is_read ? 8'h01 : 8'h00);
        for (int k = 0; k < 4; k++) q.push_back(8'((a >> (8 * k)) % 256));
        for (int k = 0; k < 4; k++) begin
            if (!is_read) q.push_back(8'((wd >> (8 * k)) % 256));
        end
        if (!is_read) q.push_back(8'h00);
        for (int k = 0; k < 4; k++) begin
            if (is_read) q.push_back(8'((rd >> (8 * k)) % 256));
        end
        return q;
    endfunction

    task automatic run_frame(input vec_t v, input int gap_idx, input int gap_cycles, input string tag);
        bq_t         exp_q;
        logic [7:0]  fb[$];
        logic        ok;
        logic        stable;
        logic [31:0] exp_d;
        int          bad;
        exp_q = model(v.is_read, v.addr, v.wdata, v.rdata);
        exp_d = v.is_read ? last_wdata : v.wdata;
        rxq.delete();
        fb.push_back(v.is_read ? 8'h01 : 8'h00);
        for (int k = 0; k < 4; k++) fb.push_back(8'((v.addr >> (8 * k)) % 256));
        for (int k = 0; k < 4; k++) begin
            if (!v.is_read) fb.push_back(8'((v.wdata >> (8 * k)) % 256));
        end
        for (int i = 0; i < fb.size(); i++) begin
            if (i == fb.size() - 1) check({tag, " valid_early"}, {31'd0, valid}, 32'd0);
            send_byte(fb[i]);
            if (i == gap_idx) repeat (gap_cycles) @(negedge clk);
        end
        wait_valid(ok);
        check({tag, " valid_rise"}, {31'd0, ok}, 32'd1);
        if (!ok) return;
        check({tag, " rnw"}, {31'd0, rnw}, {31'd0, v.is_read});
        check({tag, " addr"}, addr, v.addr);
        check({tag, " data"}, data, exp_d);
        stable = 1'b1;
        repeat (v.delay) begin
            @(negedge clk);
            if (valid !== 1'b1 || addr !== v.addr || data !== exp_d || rnw !== v.is_read) stable = 1'b0;
        end
        check({tag, " hold_stable"}, {31'd0, stable}, 32'd1);
        accept   = 1'b1;
        rdata_in = v.rdata;
        @(negedge clk);
        accept   = 1'b0;
        rdata_in = $urandom;
        check({tag, " valid_drop"}, {31'd0, valid}, 32'd0);
        if (!v.is_read) last_wdata = v.wdata;
        if (v.is_read) begin
            for (int k = 0; k < 4; k++) begin
                wait_rx(6 + k, {tag, " resp_byte"});
                send_byte(8'($urandom_range(0, 255)));
            end
        end else begin
            wait_rx(10, {tag, " done_byte"});
        end
        repeat (150) @(negedge clk);
        check({tag, " stream_len"}, rxq.size(), v.exp_len);
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < rxq.size(); i++) begin
            if (rxq[i] !== exp_q[i]) begin
                if (bad == 0) $display("FAIL %s stream[%0d]: got %h expected %h", tag, i, rxq[i], exp_q[i]);
                bad++;
            end
        end
        check({tag, " stream_bytes"}, bad, 32'd0);
    endtask

    initial begin
        vec_t   v;
        logic   ok;
        logic   seen;
        nrst       = 1'b0;
        rx         = 1'b1;
        accept     = 1'b0;
        rdata_in   = 32'd0;
        last_wdata = 32'd0;

        tbl[0] = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 3,    10};
        tbl[1] = '{1'b1, 32'h0000_0004, 32'h0000_0000, 32'h1234_5678, 0,    9};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 0,    10};
        tbl[3] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1,    9};
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0101_0101, 32'h0000_0000, 5000, 10};

        repeat (5) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_rnw", {31'd0, rnw}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_data", data, 32'd0);
        nrst = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame(tbl[i], -1, 0, $sformatf("tbl%0d", i));

        // Unknown command is dropped silently.
        rxq.delete();
        seen = 1'b0;
        send_byte(8'h5A);
        repeat (300) begin
            @(negedge clk);
            if (valid !== 1'b0) seen = 1'b1;
        end
        check("badcmd_echo", rxq.size(), 32'd0);
        check("badcmd_valid", {31'd0, seen}, 32'd0);
        v = '{1'b0, 32'h0000_2000, 32'hCAFE_F00D, 32'h0, 2, 10};
        run_frame(v, -1, 0, "after_bad");

        // Partial frame abandoned by the inter-byte timeout.
        rxq.delete();
        seen = 1'b0;
        send_byte(8'h00);
        send_byte(8'h10);
        repeat (TMO + 300) begin
            @(negedge clk);
            if (valid !== 1'b0) seen = 1'b1;
        end
        check("tmo_echoes", rxq.size(), 32'd2);
        check("tmo_no_valid", {31'd0, seen}, 32'd0);
        v = '{1'b1, 32'h0000_0040, 32'h0, 32'hA1B2_C3D4, 0, 9};
        run_frame(v, -1, 0, "after_tmo");

        // A gap shorter than the timeout must not abort the frame.
        v = '{1'b0, 32'h0000_0300, 32'h5566_7788, 32'h0, 0, 10};
        run_frame(v, 1, 700, "gap700");

        for (int r = 0; r < 6; r++) begin
            v.is_read = 1'($urandom_range(0, 1));
            v.addr    = $urandom;
            v.wdata   = $urandom;
            v.rdata   = $urandom;
            v.delay   = $urandom_range(0, 10);
            v.exp_len = v.is_read ? 9 : 10;
            run_frame(v, -1, 0, $sformatf("rnd%0d", r));
        end

        // Reset while the second response byte is on the line.
        rxq.delete();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'hA5);
        wait_valid(ok);
        check("rstmid_valid", {31'd0, ok}, 32'd1);
        accept   = 1'b1;
        rdata_in = 32'h0F1E_2D3C;
        @(negedge clk);
        accept = 1'b0;
        wait_rx(6, "rstmid_resp0");
        send_byte(8'h55);
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_tx", {31'd0, tx}, 32'd1);
        check("rstmid_valid0", {31'd0, valid}, 32'd0);
        check("rstmid_addr", addr, 32'd0);
        check("rstmid_data", data, 32'd0);
        nrst = 1'b1;
        last_wdata = 32'd0;
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) seen = 1'b1;
        end
        check("rstmid_quiet", {31'd0, seen}, 32'd0);
        v = '{1'b1, 32'h0000_0008, 32'h0, 32'h9988_7766, 0, 9};
        run_frame(v, -1, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
